key_load_ctrl: RTL and testbench



---
 rtl/key_load_pkg.sv | 35 +++
 rtl/key_fetch_timer.sv | 38 +++
 rtl/key_load_ctrl.sv | 155 +++++++++++++++
 tb/tb_key_load_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_load_pkg.sv
// -----------------------------------------------------------------------------
// key_load_pkg
// Shared types and constants for the key-load controller.
//   key_load_state_e : controller FSM states (3-bit encoding)
//   KEY_W_DEF        : default number of key bits driven to the locked netlist
//   WORD_W_DEF       : default bits returned per key-store read
//   TIMEOUT_DEF      : default limit on unacknowledged request cycles
//   calc_num_words() : key-store reads needed per load
//   calc_addr_w()    : width of the key-store word index (at least 1 bit)
// -----------------------------------------------------------------------------
package key_load_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GAP,
    COMMIT,
    DONE,
    ERR
  } key_load_state_e;

  localparam int KEY_W_DEF   = 16;
  localparam int WORD_W_DEF  = 4;
  localparam int TIMEOUT_DEF = 255;

  function automatic int calc_num_words(input int key_w, input int word_w);
    return key_w / word_w;
  endfunction

  // A single-word key still needs a 1-bit address port.
  function automatic int calc_addr_w(input int num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

endpackage

// File: rtl/key_fetch_timer.sv
// -----------------------------------------------------------------------------
// key_fetch_timer
// Clearable saturating counter that measures how long a key-store request
// has gone unacknowledged.
//   clk     : clock
//   rst_n   : synchronous active-low reset
//   clr     : clear the count (has priority over inc)
//   inc     : count one unacknowledged request cycle
//   expired : count has reached TIMEOUT
// -----------------------------------------------------------------------------
module key_fetch_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/key_load_ctrl.sv
// -----------------------------------------------------------------------------
// key_load_ctrl
// Fetches a KEY_W-bit key from a key store in WORD_W-bit words over a
// req/ack handshake, then commits it atomically to the key inputs of a
// locked netlist and raises the output enable of that netlist.
//   clk       : clock
//   rst_n     : synchronous active-low reset
//   start     : one-cycle (re)load request, ignored while busy
//   nvm_req   : read request to the key store
//   nvm_addr  : word index being read
//   nvm_ack   : key-store data valid (only looked at while nvm_req=1)
//   nvm_data  : key word, valid with nvm_ack
//   nvm_par   : even parity over nvm_data (KEY_PARITY_CHECK_EN builds only)
//   key_out   : committed key; bit i drives keyIn_0_i
//   key_valid : key_out holds a complete committed key
//   out_en    : functional-output gate of the locked block (= key_valid)
//   busy      : load in progress
//   err       : last load failed (timeout or parity)
// Build option: define KEY_PARITY_CHECK_EN to add nvm_par and reject any
// accepted word whose parity is odd.
// -----------------------------------------------------------------------------
module key_load_ctrl
  import key_load_pkg::*;
#(
  parameter  int KEY_W     = KEY_W_DEF,
  parameter  int WORD_W    = WORD_W_DEF,
  parameter  int TIMEOUT   = TIMEOUT_DEF,
  localparam int NUM_WORDS = calc_num_words(KEY_W, WORD_W),
  localparam int AW        = calc_addr_w(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              nvm_req,
  output logic [AW-1:0]     nvm_addr,
  input  logic              nvm_ack,
  input  logic [WORD_W-1:0] nvm_data,
`ifdef KEY_PARITY_CHECK_EN
  input  logic              nvm_par,
`endif
  output logic [KEY_W-1:0]  key_out,
  output logic              key_valid,
  output logic              out_en,
  output logic              busy,
  output logic              err
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WORDS - 1);

  key_load_state_e   state;
  logic [AW-1:0]     idx;
  logic [KEY_W-1:0]  shadow;
  logic              ack_take;
  logic              word_ok;
  logic              expired;
  logic              load_fail;

  // nvm_req is high exactly while in REQ, so this also discards acks
  // that arrive outside a request.
  assign ack_take = nvm_req && nvm_ack;

`ifdef KEY_PARITY_CHECK_EN
  assign word_ok = ~^{nvm_data, nvm_par};
`else
  assign word_ok = 1'b1;
`endif

  // An ack in the expiry cycle is still accepted: the ack is looked at first.
  assign load_fail = ack_take ? !word_ok : expired;

  key_fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((state != REQ) || ack_take),
    .inc     ((state == REQ) && !nvm_ack),
    .expired (expired)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the pre-edge values of all the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      // NOTE: the shadow key is reset like any other register so that no
      // stale key material survives a reset.
      shadow    <= '0;
      nvm_req   <= 1'b0;
      nvm_addr  <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      out_en    <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          // key_out keeps the previous key until the next commit.
          if (start) begin
            state     <= REQ;
            idx       <= '0;
            nvm_req   <= 1'b1;
            nvm_addr  <= '0;
            busy      <= 1'b1;
            err       <= 1'b0;
            key_valid <= 1'b0;
            out_en    <= 1'b0;
          end
        end

        REQ: begin
          if (load_fail) begin
            state     <= ERR;
            nvm_req   <= 1'b0;
            shadow    <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            out_en    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b1;
          end else if (ack_take) begin
            nvm_req <= 1'b0;
            shadow[idx*WORD_W +: WORD_W] <= nvm_data;
            if (idx == LAST_IDX) begin
              state <= COMMIT;
            end else begin
              idx   <= idx + AW'(1);
              state <= GAP;
            end
          end
        end

        // One idle cycle between words lets the timer clear.
        GAP: begin
          nvm_req  <= 1'b1;
          nvm_addr <= idx;
          state    <= REQ;
        end

        COMMIT: begin
          key_out   <= shadow;
          key_valid <= 1'b1;
          out_en    <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_load_ctrl
// Self-checking bench for key_load_ctrl. A responsive key-store model
// answers each request after a per-address delay; a transaction-level
// reference derives, from the per-word delays alone, the cycle in which
// the load completes or fails, the cycles with nvm_req high and the
// resulting key. Parity tests are built only with KEY_PARITY_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_key_load_ctrl;
  import key_load_pkg::*;

  localparam int KEY_W     = 16;
  localparam int WORD_W    = 4;
  localparam int NUM_WORDS = KEY_W / WORD_W;
  localparam int AW        = 2;
  localparam int TIMEOUT   = 255;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              nvm_req;
  logic [AW-1:0]     nvm_addr;
  logic              nvm_ack  = 1'b0;
  logic [WORD_W-1:0] nvm_data = '0;
`ifdef KEY_PARITY_CHECK_EN
  logic              nvm_par  = 1'b0;
`endif
  logic [KEY_W-1:0]  key_out;
  logic              key_valid;
  logic              out_en;
  logic              busy;
  logic              err;

  int checks   = 0;
  int failures = 0;

  // Key-store contents, response delays (in request cycles) and parity faults.
  logic [WORD_W-1:0] mem [NUM_WORDS];
  int                dly [NUM_WORDS];
  bit                par_bad [NUM_WORDS];
  bit                noise = 1'b0;
  int                wait_cnt = 0;
  logic [KEY_W-1:0]  exp_key = '0;
  logic [63:0]       last_mask;

  key_load_ctrl #(
    .KEY_W   (KEY_W),
    .WORD_W  (WORD_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .nvm_req   (nvm_req),
    .nvm_addr  (nvm_addr),
    .nvm_ack   (nvm_ack),
    .nvm_data  (nvm_data),
`ifdef KEY_PARITY_CHECK_EN
    .nvm_par   (nvm_par),
`endif
    .key_out   (key_out),
    .key_valid (key_valid),
    .out_en    (out_en),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Key store: acks the (dly+1)-th request cycle of each word; with noise
  // set it also toggles ack/data randomly while no request is pending.
  always @(negedge clk) begin
    if (nvm_req === 1'b1) begin
      if (wait_cnt >= dly[nvm_addr]) begin
        nvm_ack  = 1'b1;
        nvm_data = mem[nvm_addr];
`ifdef KEY_PARITY_CHECK_EN
        nvm_par  = (^mem[nvm_addr]) ^ par_bad[nvm_addr];
`endif
        wait_cnt = 0;
      end else begin
        nvm_ack  = 1'b0;
        nvm_data = WORD_W'($urandom);
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      nvm_ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      nvm_data = WORD_W'($urandom);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: start is sampled in cycle 0; word w is requested from cycle
  // s for dly[w]+1 cycles, the next word from s+dly[w]+2. A word that never
  // answers within TIMEOUT+1 request cycles (or has bad parity) fails the
  // load one cycle after its last request cycle; a good load is visible in
  // the cycle after the last word's gap would start.
  function automatic void model(output bit e, output int fin,
                                output logic [63:0] mask, output logic [KEY_W-1:0] k);
    int s = 1;
    e    = 1'b0;
    mask = '0;
    k    = '0;
    fin  = 0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      int last = (dly[w] > TIMEOUT) ? s + TIMEOUT : s + dly[w];
      for (int c = s; c <= last; c++) if (c < 64) mask[c] = 1'b1;
      if (dly[w] > TIMEOUT || par_bad[w]) begin
        e   = 1'b1;
        fin = last + 1;
        return;
      end
      k[w*WORD_W +: WORD_W] = mem[w];
      s = last + 2;
    end
    fin = s;
  endfunction

  task automatic run_load(input string tag, input int restart_at);
    bit               e;
    int               fin;
    logic [63:0]      m;
    logic [63:0]      om;
    logic [KEY_W-1:0] k;
    model(e, fin, m, k);
    om = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= fin; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      if (c < 64) om[c] = nvm_req;
      if (c == 1) begin
        check({tag, ".busy_start"}, 64'(busy), 64'd1);
        check({tag, ".valid_start"}, 64'({key_valid, out_en, err}), 64'd0);
        check({tag, ".key_hold_start"}, 64'(key_out), 64'(exp_key));
      end
      if (c == fin - 1) begin
        check({tag, ".valid_early"}, 64'(key_valid), 64'd0);
        check({tag, ".key_hold_end"}, 64'(key_out), 64'(exp_key));
      end
    end
    start = 1'b0;
    check({tag, ".key_valid"}, 64'(key_valid), 64'(!e));
    check({tag, ".out_en"}, 64'(out_en), 64'(!e));
    check({tag, ".busy_end"}, 64'(busy), 64'd0);
    check({tag, ".err"}, 64'(err), 64'(e));
    check({tag, ".key_out"}, 64'(key_out), e ? 64'd0 : 64'(k));
    check({tag, ".req_cycles"}, om, m);
    last_mask = om;
    exp_key   = e ? '0 : k;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req"}, 64'(nvm_req), 64'd0);
    check({tag, ".addr"}, 64'(nvm_addr), 64'd0);
    check({tag, ".key_out"}, 64'(key_out), 64'd0);
    check({tag, ".flags"}, 64'({key_valid, out_en, busy, err}), 64'd0);
  endtask

  initial begin
    mem = '{4'h3, 4'hC, 4'h5, 4'hA};

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Zero-delay store: requests in cycles 1,3,5,7, key visible in cycle 9.
    run_load("zero_delay", 0);
    check("zero_delay.req_pattern", last_mask, 64'h0000_0000_0000_00AA);
    check("zero_delay.key_const", 64'(key_out), 64'h0000_0000_0000_A5C3);

    // Three-cycle ack delay on every word.
    dly = '{3, 3, 3, 3};
    run_load("delay3", 0);

    // No ack on addr 2: timeout, then recovery with a responsive store.
    noise = 1'b1;
    dly   = '{0, 0, 1000, 0};
    run_load("timeout", 0);
    dly = '{0, 0, 0, 0};
    run_load("recover", 0);

    // Ack exactly in the expiry cycle is accepted.
    mem = '{4'h1, 4'h2, 4'h4, 4'h8};
    dly = '{0, TIMEOUT, 0, 0};
    run_load("ack_at_expiry", 0);

    // start repeated in cycle 4 of a load is ignored; reload from DONE.
    mem = '{4'h9, 4'h6, 4'hF, 4'h0};
    dly = '{0, 0, 0, 0};
    run_load("restart_ignored", 4);

    // Reset in cycle 5 of a load clears everything including key_out.
    mem = '{4'hB, 4'hE, 4'hD, 4'h7};
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) rst_n = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_reset.no_commit", 64'({nvm_req, key_valid, busy}), 64'd0);
    exp_key = '0;

`ifdef KEY_PARITY_CHECK_EN
    // Odd parity on word 0 (0x7 with par=0) fails; correct parity passes.
    mem        = '{4'h7, 4'h1, 4'h2, 4'h3};
    par_bad[0] = 1'b1;
    run_load("parity_bad", 0);
    par_bad[0] = 1'b0;
    run_load("parity_good", 0);
`endif

    // Randomised loads with small delays and occasional ignored restarts.
    for (int i = 0; i < 20; i++) begin
      int ra;
      for (int w = 0; w < NUM_WORDS; w++) begin
        mem[w] = WORD_W'($urandom);
        dly[w] = $urandom_range(0, 3);
      end
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 8)) : 0;
      run_load($sformatf("rand%0d", i), ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
